// File: rtl/food_pkg.sv
// Shared types and constants for the food spawner: FSM encoding, LFSR seed/taps, play-area defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package food_pkg;

   typedef enum logic [1:0] {
      SPAWN = 2'd0,
      CHECK = 2'd1,
      ARMED = 2'd2,
      EAT   = 2'd3
   } food_state_e;

   // x^16 + x^14 + x^13 + x^11 + 1, applied to bits 15,13,12,10 of a left-shifting register
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Play-area defaults used by the top-level parameters
   localparam int DEF_X_MIN = 200;
   localparam int DEF_Y_MIN = 200;
   localparam int DEF_STEP  = 5;
   localparam int DEF_CELLS = 61;

endpackage

// File: rtl/food_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the food position source.
// Latency: registered, one shift per clock; reset loads the seed.
// Backpressure: none, it never stalls (keeps running during freeze).
module food_lfsr
   import food_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] lfsr
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Shift left and feed the tap parity into bit 0; a nonzero seed never reaches zero
   always_comb begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   // State register, reset to the seed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/food_spawner.sv
// Places food on a random grid cell, detects head hits, pulses grow for GROW_HOLD cycles, counts score.
// Latency: spawn 1 cycle (+L body-scan cycles with FOOD_BODY_CHECK_EN), hit -> grow/score 1 cycle; all outputs registered.
// Backpressure: freeze holds FSM, counter and outputs; the LFSR keeps running. Macro: FOOD_BODY_CHECK_EN.
module food_spawner
   import food_pkg::*;
#(
   parameter int SEG_MAX   = 30,
   parameter int COORD_W   = 10,
   parameter int STEP      = DEF_STEP,
   parameter int X_MIN     = DEF_X_MIN,
   parameter int Y_MIN     = DEF_Y_MIN,
   parameter int CELLS     = DEF_CELLS,
   parameter int GROW_HOLD = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       freeze,
   input  logic [SEG_MAX*COORD_W-1:0] body_x,
   input  logic [SEG_MAX*COORD_W-1:0] body_y,
   input  logic [6:0]                 snake_length,
   output logic [COORD_W-1:0]         food_x,
   output logic [COORD_W-1:0]         food_y,
   output logic                       food_valid,
   output logic                       grow,
   output logic [7:0]                 score
);

   localparam int CNT_W = $clog2(GROW_HOLD + 1);
   localparam logic [COORD_W-1:0] X_MIN_C = COORD_W'(X_MIN);
   localparam logic [COORD_W-1:0] Y_MIN_C = COORD_W'(Y_MIN);
   localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
   localparam logic [6:0]         CELLS_C = 7'(CELLS);

   logic [15:0]        lfsr;
   logic [5:0]         rx;
   logic [5:0]         ry;
   logic               in_range;
   logic [COORD_W-1:0] new_x;
   logic [COORD_W-1:0] new_y;
   logic               head_hit;
   logic               unused_lfsr;

   food_state_e        state_q, state_d;
   logic [COORD_W-1:0] food_x_q, food_x_d;
   logic [COORD_W-1:0] food_y_q, food_y_d;
   logic               food_valid_q, food_valid_d;
   logic               grow_q, grow_d;
   logic [7:0]         score_q, score_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   food_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst),
      .lfsr  (lfsr)
   );

   assign rx          = lfsr[5:0];
   assign ry          = lfsr[13:8];
   assign unused_lfsr = ^{lfsr[15:14], lfsr[7:6]};
   assign in_range    = ({1'b0, rx} < CELLS_C) && ({1'b0, ry} < CELLS_C);
   // STEP*rx stays below 2^COORD_W for the play area, so COORD_W-wide math is exact
   assign new_x       = X_MIN_C + STEP_C * COORD_W'(rx);
   assign new_y       = Y_MIN_C + STEP_C * COORD_W'(ry);
   assign head_hit    = (body_x[COORD_W-1:0] == food_x_q) && (body_y[COORD_W-1:0] == food_y_q);

`ifdef FOOD_BODY_CHECK_EN
   localparam int         IDX_W     = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;
   localparam logic [6:0] SEG_MAX_C = 7'(SEG_MAX);

   logic [COORD_W-1:0] seg_x [SEG_MAX];
   logic [COORD_W-1:0] seg_y [SEG_MAX];
   logic [COORD_W-1:0] cand_x_q, cand_x_d;
   logic [COORD_W-1:0] cand_y_q, cand_y_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [6:0]         len_eff;
   logic [IDX_W-1:0]   last_idx;
   logic               seg_hit;

   for (genvar g = 0; g < SEG_MAX; g++) begin : g_seg
      assign seg_x[g] = body_x[g*COORD_W +: COORD_W];
      assign seg_y[g] = body_y[g*COORD_W +: COORD_W];
   end

   // Live length clamped to the bus size; an empty snake still scans the head slot
   always_comb begin
      len_eff = snake_length;
      if (snake_length == 7'd0) begin
         len_eff = 7'd1;
      end else if (snake_length > SEG_MAX_C) begin
         len_eff = SEG_MAX_C;
      end
   end

   assign last_idx = IDX_W'(len_eff - 7'd1);
   assign seg_hit  = (seg_x[idx_q] == cand_x_q) && (seg_y[idx_q] == cand_y_q);
`else
   logic unused_body;
   assign unused_body = ^{body_x[SEG_MAX*COORD_W-1:COORD_W], body_y[SEG_MAX*COORD_W-1:COORD_W],
                          snake_length};
`endif

   // Next-state and registered-output logic; freeze leaves every default (hold) in place
   always_comb begin
      state_d      = state_q;
      food_x_d     = food_x_q;
      food_y_d     = food_y_q;
      food_valid_d = food_valid_q;
      grow_d       = grow_q;
      score_d      = score_q;
      cnt_d        = cnt_q;
`ifdef FOOD_BODY_CHECK_EN
      cand_x_d     = cand_x_q;
      cand_y_d     = cand_y_q;
      idx_d        = idx_q;
`endif
      if (!freeze) begin
         unique case (state_q)
            SPAWN: begin
               grow_d       = 1'b0;
               food_valid_d = 1'b0;
               if (in_range) begin
`ifdef FOOD_BODY_CHECK_EN
                  cand_x_d = new_x;
                  cand_y_d = new_y;
                  idx_d    = '0;
                  state_d  = CHECK;
`else
                  food_x_d     = new_x;
                  food_y_d     = new_y;
                  food_valid_d = 1'b1;
                  state_d      = ARMED;
`endif
               end
            end
`ifdef FOOD_BODY_CHECK_EN
            CHECK: begin
               grow_d       = 1'b0;
               food_valid_d = 1'b0;
               if (seg_hit) begin
                  state_d = SPAWN;
               end else if (idx_q == last_idx) begin
                  food_x_d     = cand_x_q;
                  food_y_d     = cand_y_q;
                  food_valid_d = 1'b1;
                  state_d      = ARMED;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
`endif
            ARMED: begin
               if (head_hit) begin
                  food_valid_d = 1'b0;
                  grow_d       = 1'b1;
                  score_d      = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                  cnt_d        = CNT_W'(GROW_HOLD);
                  state_d      = EAT;
               end
            end
            EAT: begin
               // The low cycle that follows in SPAWN lets the movement block re-arm
               if (cnt_q <= CNT_W'(1)) begin
                  grow_d  = 1'b0;
                  state_d = SPAWN;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = SPAWN;
            end
         endcase
      end
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= SPAWN;
         food_x_q     <= '0;
         food_y_q     <= '0;
         food_valid_q <= 1'b0;
         grow_q       <= 1'b0;
         score_q      <= '0;
         cnt_q        <= '0;
`ifdef FOOD_BODY_CHECK_EN
         cand_x_q     <= '0;
         cand_y_q     <= '0;
         idx_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         food_x_q     <= food_x_d;
         food_y_q     <= food_y_d;
         food_valid_q <= food_valid_d;
         grow_q       <= grow_d;
         score_q      <= score_d;
         cnt_q        <= cnt_d;
`ifdef FOOD_BODY_CHECK_EN
         cand_x_q     <= cand_x_d;
         cand_y_q     <= cand_y_d;
         idx_q        <= idx_d;
`endif
      end
   end

   assign food_x     = food_x_q;
   assign food_y     = food_y_q;
   assign food_valid = food_valid_q;
   assign grow       = grow_q;
   assign score      = score_q;

endmodule
